// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: 8x8 -> 16-bit shift-and-add multiplier that borrows the
// processor's shared 8-bit add/sub adder one iteration per cycle.
// Optional macro ALU_MUL_SIGNED_EN adds the is_signed port and two's complement
// multiplication (arithmetic shift plus a subtract on the final iteration).
module alu_mul_sequencer #(
    parameter int ZERO_SKIP = 1,
    parameter int ITER      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  op_a,
    input  logic [7:0]  op_b,
`ifdef ALU_MUL_SIGNED_EN
    input  logic        is_signed,
`endif
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] product,
    output logic [7:0]  alu_x,
    output logic [7:0]  alu_y,
    output logic        alu_add_sub,
    input  logic [7:0]  alu_z,
    input  logic        alu_ofs
);

    // The iteration counter and operand registers are sized for 8 bits only.
    generate
        if (ITER != 8) begin : g_iter_check
            $error("alu_mul_sequencer: only ITER = 8 is supported");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [7:0]  r_mcand;
    logic [7:0]  r_acc_hi;
    logic [7:0]  r_q;
    logic [3:0]  r_cnt;

    logic        w_accept;
    logic        w_zero;
    logic        w_last;
    logic        w_sub_step;
    logic        w_newtop;
    logic        w_fill;

    assign w_accept = (r_state == S_IDLE) && in_valid;
    assign w_zero   = (ZERO_SKIP != 0) && ((op_a == 8'd0) || (op_b == 8'd0));
    assign w_last   = (r_cnt == 4'd7);

`ifdef ALU_MUL_SIGNED_EN
    logic        r_signed;

    // Signed mode: the multiplier's sign bit has weight -2^7, so the last
    // partial product is subtracted. newtop is bit 8 of the sign-extended
    // 9-bit sum, which the 8-bit adder cannot deliver directly.
    assign w_sub_step = r_signed && w_last && r_q[0];
    assign w_newtop   = r_signed ? (alu_x[7] ^ (alu_y[7] ^ alu_add_sub) ^ alu_ofs)
                                 : alu_ofs;
    assign w_fill     = r_signed ? r_acc_hi[7] : 1'b0;

    // Signedness is frozen at acceptance so a changing port cannot corrupt a run.
    always_ff @(posedge clk) begin
        if (rst)
            r_signed <= 1'b0;
        else if (w_accept)
            r_signed <= is_signed;
    end
`else
    assign w_sub_step = 1'b0;
    assign w_newtop   = alu_ofs;
    assign w_fill     = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    // Next-state: IDLE -> RUN (or straight to DONE on a skipped zero), eight
    // RUN iterations, then DONE until the consumer takes the product.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_next_state = w_zero ? S_DONE : S_RUN;
            S_RUN:   if (w_last) w_next_state = S_DONE;
            S_DONE:  if (out_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Outputs: the adder sees zeros outside RUN so it stays neutral for the ALU.
    always_comb begin
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        product     = 16'd0;
        alu_x       = 8'd0;
        alu_y       = 8'd0;
        alu_add_sub = 1'b0;
        case (r_state)
            S_IDLE: in_ready = 1'b1;
            S_RUN: begin
                alu_x       = r_acc_hi;
                alu_y       = r_mcand;
                alu_add_sub = w_sub_step;
            end
            S_DONE: begin
                out_valid = 1'b1;
                product   = {r_acc_hi, r_q};
            end
            default: ;
        endcase
    end

    // Datapath: load on acceptance, then shift {carry, acc_hi, q} right once
    // per iteration, adding mcand first when the current multiplier bit is set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= 8'd0;
            r_acc_hi <= 8'd0;
            r_q      <= 8'd0;
            r_cnt    <= 4'd0;
        end else if (w_accept) begin
            r_mcand  <= op_a;
            r_acc_hi <= 8'd0;
            r_q      <= w_zero ? 8'd0 : op_b;
            r_cnt    <= 4'd0;
        end else if (r_state == S_RUN) begin
            if (r_q[0]) begin
                r_acc_hi <= {w_newtop, alu_z[7:1]};
                r_q      <= {alu_z[0], r_q[7:1]};
            end else begin
                r_acc_hi <= {w_fill, r_acc_hi[7:1]};
                r_q      <= {r_acc_hi[0], r_q[7:1]};
            end
            r_cnt <= r_cnt + 4'd1;
        end
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench for alu_mul_sequencer. Models the shared add/sub adder
// for two instances (ZERO_SKIP = 1 and ZERO_SKIP = 0) and checks products
// against plain integer multiplication.
module tb_alu_mul_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  op_a = 8'd0, op_b = 8'd0;
    // main instance (ZERO_SKIP = 1)
    logic        iv = 1'b0, ordy = 1'b0;
    logic        rdy, ov, aas, aofs;
    logic [15:0] prod;
    logic [7:0]  ax, ay, az;
    // second instance (ZERO_SKIP = 0)
    logic        iv0 = 1'b0, ordy0 = 1'b0;
    logic        rdy0, ov0, aas0, aofs0;
    logic [15:0] prod0;
    logic [7:0]  ax0, ay0, az0;
`ifdef ALU_MUL_SIGNED_EN
    logic        sgn_in = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // shared adder model: subtract is X + ~Y + 1, ofs is the carry-out
    assign {aofs, az}   = {1'b0, ax}  + {1'b0, ay  ^ {8{aas}}}  + {8'd0, aas};
    assign {aofs0, az0} = {1'b0, ax0} + {1'b0, ay0 ^ {8{aas0}}} + {8'd0, aas0};

    alu_mul_sequencer #(.ZERO_SKIP(1), .ITER(8)) dut (
        .clk(clk), .rst(rst), .in_valid(iv), .in_ready(rdy),
        .op_a(op_a), .op_b(op_b),
`ifdef ALU_MUL_SIGNED_EN
        .is_signed(sgn_in),
`endif
        .out_valid(ov), .out_ready(ordy), .product(prod),
        .alu_x(ax), .alu_y(ay), .alu_add_sub(aas), .alu_z(az), .alu_ofs(aofs)
    );

    alu_mul_sequencer #(.ZERO_SKIP(0), .ITER(8)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(rdy0),
        .op_a(op_a), .op_b(op_b),
`ifdef ALU_MUL_SIGNED_EN
        .is_signed(1'b0),
`endif
        .out_valid(ov0), .out_ready(ordy0), .product(prod0),
        .alu_x(ax0), .alu_y(ay0), .alu_add_sub(aas0), .alu_z(az0), .alu_ofs(aofs0)
    );

    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic s);
        int p;
        if (s) p = int'($signed(a)) * int'($signed(b));
        else   p = int'(a) * int'(b);
        return p[15:0];
    endfunction

    task automatic do_reset();
        @(negedge clk); rst = 1'b1; iv = 1'b0; iv0 = 1'b0; ordy = 1'b0; ordy0 = 1'b0;
        @(posedge clk); @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total++; if (rdy !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", rdy); end
        total++; if (ov !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", ov); end
        total++; if (prod !== 16'h0) begin bad++; $display("FAIL reset_product got=%h want=0000", prod); end
        total++; if ({ax, ay, aas} !== 17'h0) begin bad++; $display("FAIL reset_alu got=%h/%h/%b want=0", ax, ay, aas); end
        total++; if ({rdy0, ov0, prod0} !== {1'b1, 17'h0}) begin bad++; $display("FAIL reset_dut0 got=%b/%b/%h", rdy0, ov0, prod0); end
    endtask

    // One multiply on the main instance: latency is counted in rising edges
    // from the acceptance edge to out_valid being seen.
    task automatic mul_check(input string name, input logic [7:0] a, input logic [7:0] b,
                             input logic s, input bit pulse, input int hold);
        logic [15:0] exp;
        int          exp_lat, lat;
        logic        last_as;
        exp     = model(a, b, s);
        exp_lat = (a == 8'd0 || b == 8'd0) ? 0 : 8;
        last_as = 1'b0;
        @(negedge clk);
        iv = 1'b1; op_a = a; op_b = b;
`ifdef ALU_MUL_SIGNED_EN
        sgn_in = s;
`endif
        @(posedge clk);
        #1 iv = 1'b0; op_a = 8'($urandom); op_b = 8'($urandom);
`ifdef ALU_MUL_SIGNED_EN
        sgn_in = ~s;
`endif
        lat = 0;
        @(negedge clk);
        while (!ov && lat < 20) begin
            total++; if (rdy !== 1'b0) begin bad++; $display("FAIL %s busy_in_ready got=%b want=0", name, rdy); end
            last_as = aas;
            if (pulse && lat == 3) begin iv = 1'b1; op_a = 8'h11; op_b = 8'h22; end
            @(posedge clk); lat++;
            #1 iv = 1'b0;
            @(negedge clk);
        end
        total++; if (lat != exp_lat) begin bad++; $display("FAIL %s latency got=%0d want=%0d", name, lat, exp_lat); end
        total++; if (prod !== exp) begin bad++; $display("FAIL %s product got=%h want=%h", name, prod, exp); end
        if (exp_lat == 8) begin
            total++;
            if (last_as !== (s & b[7])) begin bad++; $display("FAIL %s last_add_sub got=%b want=%b", name, last_as, s & b[7]); end
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); @(negedge clk);
            total++;
            if (ov !== 1'b1 || prod !== exp) begin bad++; $display("FAIL %s hold got=%b/%h want=1/%h", name, ov, prod, exp); end
        end
        ordy = 1'b1;
        @(posedge clk);
        #1 ordy = 1'b0;
        @(negedge clk);
        total++;
        if (ov !== 1'b0 || rdy !== 1'b1) begin bad++; $display("FAIL %s release got=%b/%b want=0/1", name, ov, rdy); end
    endtask

    task automatic test_basic();
        mul_check("d_x_b", 8'h0D, 8'h0B, 1'b0, 1'b0, 3);
        mul_check("ff_x_ff", 8'hFF, 8'hFF, 1'b0, 1'b0, 0);
        mul_check("80_x_02", 8'h80, 8'h02, 1'b0, 1'b0, 1);
        mul_check("zero_skip", 8'h00, 8'h37, 1'b0, 1'b0, 1);
        mul_check("zero_skip_b", 8'h5A, 8'h00, 1'b0, 1'b0, 0);
    endtask

    task automatic test_no_zero_skip();
        int lat;
        @(negedge clk);
        iv0 = 1'b1; op_a = 8'h00; op_b = 8'h37;
        @(posedge clk);
        #1 iv0 = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!ov0 && lat < 20) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        total++; if (lat != 8) begin bad++; $display("FAIL nozs_latency got=%0d want=8", lat); end
        total++; if (prod0 !== 16'h0) begin bad++; $display("FAIL nozs_product got=%h want=0000", prod0); end
        ordy0 = 1'b1;
        @(posedge clk);
        #1 ordy0 = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        iv = 1'b1; op_a = 8'h77; op_b = 8'h99;
        @(posedge clk);
        #1 iv = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++;
        if (rdy !== 1'b1 || ov !== 1'b0 || ax !== 8'h0) begin
            bad++; $display("FAIL midrun_reset got=%b/%b/%h want=1/0/00", rdy, ov, ax);
        end
        mul_check("after_reset_pulse", 8'h03, 8'h05, 1'b0, 1'b1, 0);
        repeat (3) begin
            @(posedge clk); @(negedge clk);
            total++;
            if (ov !== 1'b0 || rdy !== 1'b1) begin bad++; $display("FAIL no_recapture got=%b/%b want=0/1", ov, rdy); end
        end
    endtask

    task automatic test_out_ready_idle();
        @(negedge clk); ordy = 1'b1;
        @(posedge clk); @(negedge clk);
        total++;
        if (ov !== 1'b0 || rdy !== 1'b1) begin bad++; $display("FAIL idle_out_ready got=%b/%b want=0/1", ov, rdy); end
        ordy = 1'b0;
    endtask

`ifdef ALU_MUL_SIGNED_EN
    task automatic test_signed();
        mul_check("s_fd_x_05", 8'hFD, 8'h05, 1'b1, 1'b0, 0);
        mul_check("s_05_x_fd", 8'h05, 8'hFD, 1'b1, 1'b0, 0);
        mul_check("s_80_x_80", 8'h80, 8'h80, 1'b1, 1'b0, 0);
        mul_check("s_fd_x_05_u", 8'hFD, 8'h05, 1'b0, 1'b0, 0);
    endtask
`endif

    task automatic test_random();
        logic [7:0] a, b;
        logic       s;
        for (int n = 0; n < 40; n++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            if ($urandom_range(0, 7) == 0) a = 8'h00;
            if ($urandom_range(0, 7) == 0) b = 8'h00;
`ifdef ALU_MUL_SIGNED_EN
            s = 1'($urandom_range(0, 1));
`else
            s = 1'b0;
`endif
            mul_check("random", a, b, s, 1'b0, int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_no_zero_skip();
        test_reset_mid_run();
        test_out_ready_idle();
`ifdef ALU_MUL_SIGNED_EN
        test_signed();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
